// File: rtl/l1_pkg.sv
// l1_pkg: shared widths, L1 address/return-entry types and FIFO sizing helper for the L1 read-data return path
package l1_pkg;

    localparam int nstrms       = 64;
    localparam int nstrms_width = $clog2(nstrms);
    localparam int ptr_width    = 1;
    localparam int data_width   = 64;
    localparam int addr_width   = nstrms_width + ptr_width;

    typedef struct packed {
        logic [nstrms_width-1:0] sid;
        logic [ptr_width-1:0]    ptr;
    } l1_addr_t;

    typedef struct packed {
        logic [data_width-1:0]   data;
        logic [nstrms_width-1:0] sid;
    } l1_ret_t;

    // Smallest return FIFO that sustains one read per cycle for a given BRAM latency
    function automatic int min_fifo_depth(input int bram_lat);
        return bram_lat + 2;
    endfunction

endpackage

// File: rtl/l1_rd_data_ret_if.sv
// l1_rd_data_ret_if: address, BRAM and AFU read-data handshakes of the L1 read-data return stage
interface l1_rd_data_ret_if;
    import l1_pkg::*;

    logic                    i_addr_v;
    logic                    i_addr_r;
    logic [ptr_width-1:0]    i_addr_ptr;
    logic [nstrms_width-1:0] i_addr_sid;
    logic                    o_bram_re;
    logic [addr_width-1:0]   o_bram_addr;
    logic [data_width-1:0]   i_bram_data;
    logic                    o_rd_v;
    logic                    o_rd_r;
    logic [data_width-1:0]   o_rd_data;
    logic [nstrms_width-1:0] o_rd_sid;

    modport master (
        output i_addr_v, i_addr_ptr, i_addr_sid, i_bram_data, o_rd_r,
        input  i_addr_r, o_bram_re, o_bram_addr, o_rd_v, o_rd_data, o_rd_sid
    );

    modport slave (
        input  i_addr_v, i_addr_ptr, i_addr_sid, i_bram_data, o_rd_r,
        output i_addr_r, o_bram_re, o_bram_addr, o_rd_v, o_rd_data, o_rd_sid
    );

endinterface

// File: rtl/l1_ret_fifo.sv
// l1_ret_fifo: first-word-fall-through circular FIFO; head reads as zero while empty so nothing stale is ever shown
module l1_ret_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [width-1:0]           din,
    input  logic                       pop,
    output logic [width-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int pw = depth > 1 ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [pw-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
        return p == pw'(depth - 1) ? '0 : p + 1'b1;
    endfunction

    // Pointer wrap, occupancy and storage update; a pop on empty is ignored
    always_comb begin
        empty  = cnt_q == '0;
        full   = cnt_q == cw'(depth);
        count  = cnt_q;
        do_pop = pop & ~empty;
        mem_d  = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d   = push ? nxt(wr_q) : wr_q;
        rd_d   = do_pop ? nxt(rd_q) : rd_q;
        cnt_d  = (push & ~do_pop) ? cnt_q + 1'b1 : ((~push & do_pop) ? cnt_q - 1'b1 : cnt_q);
        dout   = empty ? '0 : mem_q[rd_q];
    end

    // Storage and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/l1_rd_data_ret.sv
// l1_rd_data_ret: credit-protected L1 BRAM read issue and in-order data return to the AFU.
// Optional event counters are built when L1_RD_DATA_RET_COUNTERS_EN is defined.
module l1_rd_data_ret
    import l1_pkg::*;
#(
    parameter int bram_lat   = 2,
    parameter int fifo_depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    l1_rd_data_ret_if.slave  bus,
    output logic             o_idle
`ifdef L1_RD_DATA_RET_COUNTERS_EN
    ,
    output logic [31:0]      o_cnt_acc,
    output logic [31:0]      o_cnt_pop,
    output logic [31:0]      o_cnt_stall
`endif
);

    localparam int cnt_width = $clog2(fifo_depth + 1);

    logic [cnt_width-1:0]    credit_q, credit_d;
    logic [bram_lat-1:0]     vld_q, vld_d;
    logic [nstrms_width-1:0] sid_q [bram_lat];
    logic [nstrms_width-1:0] sid_d [bram_lat];
    logic                    acc, pop, full, empty;
    logic [cnt_width-1:0]    fifo_cnt;
    l1_addr_t                addr;
    l1_ret_t                 push_ent, head;

    // Credit-gated accept, BRAM issue (address zeroed when idle) and credit accounting
    always_comb begin
        addr            = '{sid: bus.i_addr_sid, ptr: bus.i_addr_ptr};
        bus.i_addr_r    = credit_q != '0;
        acc             = bus.i_addr_v & (credit_q != '0);
        pop             = ~empty & bus.o_rd_r;
        bus.o_bram_re   = acc;
        bus.o_bram_addr = acc ? addr : '0;
        credit_d        = (acc & ~pop) ? credit_q - 1'b1 : ((~acc & pop) ? credit_q + 1'b1 : credit_q);
        o_idle          = credit_q == cnt_width'(fifo_depth);
    end

    // Latency pipe tracks which cycles carry BRAM data and for which stream; head of FIFO drives the AFU
    always_comb begin
        vld_d    = '0;
        sid_d    = sid_q;
        vld_d[0] = acc;
        sid_d[0] = acc ? bus.i_addr_sid : '0;
        for (int i = 1; i < bram_lat; i++) begin
            vld_d[i] = vld_q[i-1];
            sid_d[i] = sid_q[i-1];
        end
        push_ent      = '{data: bus.i_bram_data, sid: sid_q[bram_lat-1]};
        bus.o_rd_v    = ~empty;
        bus.o_rd_data = head.data;
        bus.o_rd_sid  = head.sid;
    end

    // Credit and latency-pipe registers; reset drops anything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q <= cnt_width'(fifo_depth);
            vld_q    <= '0;
            sid_q    <= '{default: '0};
        end else begin
            credit_q <= credit_d;
            vld_q    <= vld_d;
            sid_q    <= sid_d;
        end
    end

    l1_ret_fifo #(
        .width ($bits(l1_ret_t)),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (vld_q[bram_lat-1]),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    a_credit_max: assert property (@(posedge clk) disable iff (reset)
        credit_q <= cnt_width'(fifo_depth));
    a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && !acc && credit_q == cnt_width'(fifo_depth)));
    a_push_full: assert property (@(posedge clk) disable iff (reset)
        !(vld_q[bram_lat-1] && full && !pop));
    a_conserve: assert property (@(posedge clk) disable iff (reset)
        int'(fifo_cnt) + $countones(vld_q) + int'(credit_q) == fifo_depth);

`ifdef L1_RD_DATA_RET_COUNTERS_EN
    logic [31:0] cnt_acc_q, cnt_acc_d, cnt_pop_q, cnt_pop_d, cnt_stall_q, cnt_stall_d;

    // Free-running event counters, wrapping modulo 2^32
    always_comb begin
        cnt_acc_d   = cnt_acc_q + 32'(acc);
        cnt_pop_d   = cnt_pop_q + 32'(pop);
        cnt_stall_d = cnt_stall_q + 32'(bus.i_addr_v & (credit_q == '0));
        o_cnt_acc   = cnt_acc_q;
        o_cnt_pop   = cnt_pop_q;
        o_cnt_stall = cnt_stall_q;
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_acc_q   <= '0;
            cnt_pop_q   <= '0;
            cnt_stall_q <= '0;
        end else begin
            cnt_acc_q   <= cnt_acc_d;
            cnt_pop_q   <= cnt_pop_d;
            cnt_stall_q <= cnt_stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_l1_rd_data_ret.sv
// tb_l1_rd_data_ret: directed stimulus with a queue-based return model checked every cycle, plus literal spot checks
module tb_l1_rd_data_ret;
    import l1_pkg::*;

    logic clk = 0;
    logic reset;
    logic idle;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    l1_rd_data_ret_if bus ();

`ifdef L1_RD_DATA_RET_COUNTERS_EN
    logic [31:0] cnt_acc, cnt_pop, cnt_stall;
`endif

    l1_rd_data_ret dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .o_idle (idle)
`ifdef L1_RD_DATA_RET_COUNTERS_EN
        ,
        .o_cnt_acc   (cnt_acc),
        .o_cnt_pop   (cnt_pop),
        .o_cnt_stall (cnt_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] data_of(input logic [6:0] a);
        return {16'hC0DE, 41'h0, a};
    endfunction

    task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // BRAM: two-cycle read latency, garbage on the bus when no read is returning
    bit       bv [2];
    bit [6:0] bq [2];
    always @(posedge clk) begin
        bv[1] <= bv[0];
        bq[1] <= bq[0];
        bv[0] <= bus.o_bram_re;
        bq[0] <= bus.o_bram_addr;
    end
    assign bus.i_bram_data = bv[1] ? data_of(bq[1]) : 64'hDEAD_BEEF_DEAD_BEEF;

    // Model: each accepted read becomes visible bram_lat+1 cycles later, in order; credits = 4 - outstanding
    typedef struct {
        logic [63:0] d;
        logic [5:0]  s;
        int          rdy;
    } ent_t;
    ent_t q[$];
    int   n_acc = 0, n_pop = 0, n_stall = 0;
    int   pops[$];

    always @(posedge clk) begin
        bit m_rdy;
        if (reset) begin
            q.delete();
            n_acc = 0;
            n_pop = 0;
            n_stall = 0;
        end else begin
            m_rdy = q.size() < 4;
            if (q.size() > 0 && q[0].rdy <= cyc && bus.o_rd_r) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (bus.i_addr_v && m_rdy) begin
                q.push_back('{d: data_of({bus.i_addr_sid, bus.i_addr_ptr}), s: bus.i_addr_sid, rdy: cyc + 3});
                n_acc++;
            end
            if (bus.i_addr_v && !m_rdy) n_stall++;
        end
        cyc++;
    end

    // Compare DUT against the model every cycle out of reset
    always @(negedge clk) begin
        bit       acc, ev;
        logic [6:0] ea;
        if (!reset) begin
            acc = bus.i_addr_v && q.size() < 4;
            ea  = acc ? {bus.i_addr_sid, bus.i_addr_ptr} : 7'd0;
            ev  = q.size() > 0 && q[0].rdy <= cyc;
            ck("addr_r", bus.i_addr_r, q.size() < 4);
            ck("bram_re", bus.o_bram_re, acc);
            ck("bram_addr", bus.o_bram_addr, ea);
            ck("rd_v", bus.o_rd_v, ev);
            if (ev) begin
                ck("rd_data", bus.o_rd_data, q[0].d);
                ck("rd_sid", bus.o_rd_sid, q[0].s);
            end
            ck("idle", idle, q.size() == 0);
            if (bus.o_rd_v && bus.o_rd_r) pops.push_back(cyc);
        end
    end

    initial begin
        int nacc, stalls, span;
        logic [63:0] h;
        reset = 1;
        bus.i_addr_v = 0;
        bus.i_addr_sid = 0;
        bus.i_addr_ptr = 0;
        bus.o_rd_r = 1;
        #1;
        ck("rst_rd_v", bus.o_rd_v, 0);
        ck("rst_addr_r", bus.i_addr_r, 1);
        ck("rst_bram_re", bus.o_bram_re, 0);
        ck("rst_idle", idle, 1);
        ck("rst_rd_data", bus.o_rd_data, 0);
        ck("rst_rd_sid", bus.o_rd_sid, 0);
        tick(2);
        reset = 0;
        tick(9);

        // Single read: sid=5 ptr=1
        bus.i_addr_v = 1;
        bus.i_addr_sid = 5;
        bus.i_addr_ptr = 1;
        #1;
        ck("t1_re", bus.o_bram_re, 1);
        ck("t1_addr", bus.o_bram_addr, 7'd11);
        tick;
        bus.i_addr_v = 0;
        tick(2);
        ck("t1_rd_v", bus.o_rd_v, 1);
        ck("t1_sid", bus.o_rd_sid, 5);
        ck("t1_data", bus.o_rd_data, 64'hC0DE_0000_0000_000B);
        ck("t1_busy", idle, 0);
        tick;
        ck("t1_idle", idle, 1);
        ck("t1_rd_v_off", bus.o_rd_v, 0);

        // Streaming: 16 back-to-back reads
        pops.delete();
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            bus.i_addr_v = 1;
            bus.i_addr_sid = 6'(i + 8);
            bus.i_addr_ptr = 1'(i);
            #1;
            if (!bus.i_addr_r) stalls++;
            tick;
        end
        bus.i_addr_v = 0;
        tick(6);
        span = pops.size() > 0 ? pops[$] - pops[0] : -1;
        ck("t2_stalls", 64'(stalls), 0);
        ck("t2_pops", 64'(pops.size()), 16);
        ck("t2_span", 64'(span), 15);

        // Backpressure: credits cap accepts at the FIFO depth
        pops.delete();
        bus.o_rd_r = 0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.i_addr_v = 1;
            bus.i_addr_sid = 6'(20 + i);
            bus.i_addr_ptr = 0;
            #1;
            nacc += int'(bus.o_bram_re);
            tick;
        end
        bus.i_addr_v = 0;
        ck("t3_accepts", 64'(nacc), 4);
        ck("t3_r_low", bus.i_addr_r, 0);
        tick(3);
        ck("t3_full_v", bus.o_rd_v, 1);
        ck("t3_head_sid", bus.o_rd_sid, 20);
        h = bus.o_rd_data;
        tick(2);
        ck("t3_hold", bus.o_rd_data, h);
        bus.o_rd_r = 1;
        #1;
        ck("t3_r_at_pop", bus.i_addr_r, 0);
        tick;
        ck("t3_r_after_pop", bus.i_addr_r, 1);
        tick(4);
        ck("t3_drained", bus.o_rd_v, 0);
        ck("t3_pops", 64'(pops.size()), 4);

        // Accept and pop together with one credit left
        bus.o_rd_r = 0;
        for (int i = 0; i < 3; i++) begin
            bus.i_addr_v = 1;
            bus.i_addr_sid = 6'(40 + i);
            tick;
        end
        bus.i_addr_v = 0;
        tick(4);
        bus.i_addr_v = 1;
        bus.i_addr_sid = 50;
        bus.o_rd_r = 1;
        #1;
        ck("t4_r_credit1", bus.i_addr_r, 1);
        tick;
        bus.i_addr_v = 0;
        bus.o_rd_r = 0;
        #1;
        ck("t4_credit_kept", bus.i_addr_r, 1);
        bus.i_addr_v = 1;
        bus.i_addr_sid = 51;
        tick;
        bus.i_addr_v = 0;
        #1;
        ck("t4_credit_zero", bus.i_addr_r, 0);
        bus.o_rd_r = 1;
        tick(8);
        ck("t4_idle", idle, 1);

        // Reset with two reads in flight and one in the FIFO
        bus.o_rd_r = 0;
        bus.i_addr_v = 1;
        bus.i_addr_sid = 60;
        tick;
        bus.i_addr_v = 0;
        tick(3);
        ck("t5_one_queued", bus.o_rd_v, 1);
        bus.i_addr_v = 1;
        bus.i_addr_sid = 61;
        tick;
        bus.i_addr_sid = 62;
        tick;
        bus.i_addr_v = 0;
        #1;
        reset = 1;
        #1;
        ck("t5_rd_v", bus.o_rd_v, 0);
        ck("t5_rd_data", bus.o_rd_data, 0);
        ck("t5_rd_sid", bus.o_rd_sid, 0);
        ck("t5_idle", idle, 1);
        ck("t5_addr_r", bus.i_addr_r, 1);
        tick(2);
        reset = 0;
        bus.o_rd_r = 1;
        tick(6);
        ck("t5_no_stale", bus.o_rd_v, 0);
        bus.o_rd_r = 0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.i_addr_v = 1;
            bus.i_addr_sid = 6'(i);
            #1;
            nacc += int'(bus.o_bram_re);
            tick;
        end
        bus.i_addr_v = 0;
        ck("t5_credit4", 64'(nacc), 4);
        bus.o_rd_r = 1;
        tick(8);
        ck("t5_idle_end", idle, 1);

`ifdef L1_RD_DATA_RET_COUNTERS_EN
        ck("cnt_acc", cnt_acc, 32'(n_acc));
        ck("cnt_pop", cnt_pop, 32'(n_pop));
        ck("cnt_stall", cnt_stall, 32'(n_stall));
        ck("cnt_acc_lit", cnt_acc, 32'd4);
        ck("cnt_stall_lit", cnt_stall, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
